// File: rtl/pattern_checker_if.sv
// Stream and status bundle between a pattern source/host and pattern_checker.
// The checker takes the slave side; the host or bench takes the master side.
interface pattern_checker_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  clear;
   logic [1:0]            mode;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_valid;
   logic                  locked;
   logic [CNT_WIDTH-1:0]  err_count;
   logic                  err_sticky;
   logic [DATA_WIDTH-1:0] first_exp;
   logic [DATA_WIDTH-1:0] first_got;

   modport master (
      output clear, mode, data_in, data_valid,
      input  locked, err_count, err_sticky, first_exp, first_got
   );

   modport slave (
      input  clear, mode, data_in, data_valid,
      output locked, err_count, err_sticky, first_exp, first_got
   );
endinterface

// File: rtl/pattern_checker.sv
// Stream pattern checker: hunts for lock on an inc/dec/const/walking pattern, then
// counts mismatching beats (saturating), captures the first error and resyncs on errors.
module pattern_checker #(
   parameter int DATA_WIDTH    = 32,
   parameter int CNT_WIDTH     = 16,
   parameter int LOCK_THRESH   = 4,
   parameter int UNLOCK_THRESH = 8
) (
   input  logic            clk,
   input  logic            rstn,
   pattern_checker_if.slave bus
);
   localparam int RUN_MAX = (LOCK_THRESH > UNLOCK_THRESH) ? LOCK_THRESH : UNLOCK_THRESH;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;
   typedef logic [DATA_WIDTH-1:0] word_t;

   state_e               state_q, state_d;
   word_t                expected_q, expected_d;
   logic                 primed_q, primed_d;
   logic [RUN_W-1:0]     run_q, run_d, run_inc;
   logic [1:0]           mode_r_q, mode_r_d;
   logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
   logic                 err_sticky_q, err_sticky_d;
   word_t                first_exp_q, first_exp_d;
   word_t                first_got_q, first_got_d;
   logic                 is_match;

   function automatic word_t next_word(input word_t d, input logic [1:0] m);
      case (m)
         2'd0:    return d + word_t'(1);
         2'd1:    return d - word_t'(1);
         2'd2:    return d;
         default: return {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};
      endcase
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d      = state_q;
      expected_d   = expected_q;
      primed_d     = primed_q;
      run_d        = run_q;
      mode_r_d     = bus.mode;
      err_count_d  = err_count_q;
      err_sticky_d = err_sticky_q;
      first_exp_d  = first_exp_q;
      first_got_d  = first_got_q;
      run_inc      = run_q + RUN_W'(1);
      is_match     = (bus.data_in == expected_q);

      if (bus.clear) begin
         state_d      = HUNT;
         primed_d     = 1'b0;
         run_d        = '0;
         err_count_d  = '0;
         err_sticky_d = 1'b0;
         first_exp_d  = '0;
         first_got_d  = '0;
      end else if (bus.mode != mode_r_q) begin
         // The beat arriving with a new mode was generated under unknown rules, so drop it.
         state_d  = HUNT;
         primed_d = 1'b0;
         run_d    = '0;
      end else if (bus.data_valid) begin
         expected_d = next_word(bus.data_in, mode_r_q);
         if (state_q == HUNT) begin
            if (!primed_q) begin
               primed_d = 1'b1;
               run_d    = '0;
            end else if (is_match) begin
               if (run_inc == RUN_W'(LOCK_THRESH)) begin
                  state_d = LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_inc;
               end
            end else begin
               run_d = '0;
            end
         end else if (is_match) begin
            run_d = '0;
         end else begin
            if (err_count_q != '1) err_count_d = err_count_q + CNT_WIDTH'(1);
            if (!err_sticky_q) begin
               err_sticky_d = 1'b1;
               first_exp_d  = expected_q;
               first_got_d  = bus.data_in;
            end
            if (run_inc == RUN_W'(UNLOCK_THRESH)) begin
               state_d  = HUNT;
               primed_d = 1'b1;
               run_d    = '0;
            end else begin
               run_d = run_inc;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= HUNT;
         expected_q   <= '0;
         primed_q     <= 1'b0;
         run_q        <= '0;
         mode_r_q     <= 2'd0;
         err_count_q  <= '0;
         err_sticky_q <= 1'b0;
         first_exp_q  <= '0;
         first_got_q  <= '0;
      end else begin
         state_q      <= state_d;
         expected_q   <= expected_d;
         primed_q     <= primed_d;
         run_q        <= run_d;
         mode_r_q     <= mode_r_d;
         err_count_q  <= err_count_d;
         err_sticky_q <= err_sticky_d;
         first_exp_q  <= first_exp_d;
         first_got_q  <= first_got_d;
      end
   end

   assign bus.locked     = (state_q == LOCKED);
   assign bus.err_count  = err_count_q;
   assign bus.err_sticky = err_sticky_q;
   assign bus.first_exp  = first_exp_q;
   assign bus.first_got  = first_got_q;
endmodule

// File: tb/tb_pattern_checker.sv
// Randomised scoreboard bench for pattern_checker: a behavioural model predicts the
// outputs after every cycle; a monitor compares them one cycle later.
module tb_pattern_checker;
   localparam int W    = 32;
   localparam int CW   = 4;
   localparam int LT   = 4;
   localparam int UT   = 8;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      bit          locked;
      int          errs;
      bit          sticky;
      logic [31:0] fe;
      logic [31:0] fg;
   } snap_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   pattern_checker_if #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) bus ();

   pattern_checker #(
      .DATA_WIDTH(W), .CNT_WIDTH(CW), .LOCK_THRESH(LT), .UNLOCK_THRESH(UT)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_errors = 0;
   string cur_test = "reset";
   snap_t exp_q[$];

   // Behavioural model: lock is a streak of predicted beats, errors are predicted misses.
   bit          m_locked, m_primed;
   int          m_streak, m_errs;
   logic [31:0] m_exp, m_fe, m_fg;
   logic [1:0]  m_mode;
   bit          m_sticky;
   logic [1:0]  cur_mode;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s/%s: got %h want %h", cur_test, name, got, want);
      end
   endtask

   function automatic logic [31:0] pat_next(input logic [31:0] d, input logic [1:0] m);
      case (m)
         2'd0:    return d + 32'd1;
         2'd1:    return d - 32'd1;
         2'd2:    return d;
         default: return (d << 1) | (d >> 31);
      endcase
   endfunction

   task automatic model_reset();
      m_locked = 0; m_primed = 0; m_streak = 0; m_errs = 0;
      m_exp = '0; m_fe = '0; m_fg = '0; m_mode = 2'd0; m_sticky = 0;
   endtask

   task automatic model_step(input bit clr, input logic [1:0] md, input logic [31:0] d, input bit v);
      bit miss;
      if (clr) begin
         m_locked = 0; m_primed = 0; m_streak = 0;
         m_errs = 0; m_sticky = 0; m_fe = '0; m_fg = '0;
      end else if (md != m_mode) begin
         m_locked = 0; m_primed = 0; m_streak = 0;
      end else if (v) begin
         miss = (d != m_exp);
         if (!m_locked) begin
            if (!m_primed) begin
               m_primed = 1; m_streak = 0;
            end else if (miss) begin
               m_streak = 0;
            end else begin
               m_streak++;
               if (m_streak == LT) begin m_locked = 1; m_streak = 0; end
            end
         end else if (!miss) begin
            m_streak = 0;
         end else begin
            m_errs = (m_errs == CMAX) ? CMAX : m_errs + 1;
            if (!m_sticky) begin m_sticky = 1; m_fe = m_exp; m_fg = d; end
            m_streak++;
            if (m_streak == UT) begin m_locked = 0; m_primed = 1; m_streak = 0; end
         end
         m_exp = pat_next(d, md);
      end
      m_mode = md;
   endtask

   task automatic cycle(input bit clr, input logic [1:0] md, input logic [31:0] d, input bit v);
      snap_t s;
      @(negedge clk);
      bus.clear = clr; bus.mode = md; bus.data_in = d; bus.data_valid = v;
      cur_mode = md;
      model_step(clr, md, d, v);
      s.locked = m_locked; s.errs = m_errs; s.sticky = m_sticky; s.fe = m_fe; s.fg = m_fg;
      exp_q.push_back(s);
   endtask

   task automatic run_seq(input logic [1:0] md, input logic [31:0] start, input int n);
      logic [31:0] d;
      d = start;
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, md, d, 1'b1);
         d = pat_next(d, md);
      end
   endtask

   task automatic beat(input logic [31:0] d);
      cycle(1'b0, cur_mode, d, 1'b1);
   endtask

   task automatic idle(input logic [1:0] md);
      cycle(1'b0, md, 32'h0, 1'b0);
   endtask

   task automatic do_clear();
      cycle(1'b1, cur_mode, 32'h0, 1'b0);
   endtask

   task automatic check_all_zero();
      check("rst_locked", {31'd0, bus.locked}, 32'd0);
      check("rst_errs", {28'd0, bus.err_count}, 32'd0);
      check("rst_sticky", {31'd0, bus.err_sticky}, 32'd0);
      check("rst_first_exp", bus.first_exp, 32'd0);
      check("rst_first_got", bus.first_got, 32'd0);
   endtask

   // Monitor: outputs are valid every cycle, so pop one prediction per clock.
   initial begin
      snap_t s;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check("locked", {31'd0, bus.locked}, {31'd0, s.locked});
            check("err_count", {28'd0, bus.err_count}, s.errs);
            check("err_sticky", {31'd0, bus.err_sticky}, {31'd0, s.sticky});
            check("first_exp", bus.first_exp, s.fe);
            check("first_got", bus.first_got, s.fg);
         end
      end
   end

   initial begin
      logic [31:0] d;
      bus.clear = 0; bus.mode = 2'd0; bus.data_in = '0; bus.data_valid = 0;
      cur_mode = 2'd0;
      model_reset();
      #1;
      check_all_zero();
      #11;
      rstn = 1'b1;

      cur_test = "lock";
      run_seq(2'd0, 32'h10, 5);
      idle(2'd0);

      cur_test = "single_error";
      beat(32'h15); beat(32'h99); beat(32'h9A); beat(32'h9B);
      idle(2'd0);

      cur_test = "wrap_inc";
      do_clear();
      run_seq(2'd0, 32'hFFFF_FFFA, 8);
      cur_test = "wrap_dec";
      idle(2'd1);
      run_seq(2'd1, 32'd6, 8);
      cur_test = "walking";
      idle(2'd3);
      run_seq(2'd3, 32'd1, 33);
      cur_test = "constant";
      idle(2'd2);
      run_seq(2'd2, 32'hA5A5_5A5A, 8);

      cur_test = "unlock";
      idle(2'd0);
      do_clear();
      run_seq(2'd0, 32'h1000, 6);
      for (int i = 0; i < UT; i++) begin
         d = $urandom;
         if (d == m_exp) d = ~d;
         beat(d);
      end
      idle(2'd0);
      cur_test = "relock";
      run_seq(2'd0, m_exp, 4);
      idle(2'd0);

      cur_test = "saturate";
      do_clear();
      run_seq(2'd0, 32'h2000, 6);
      for (int i = 0; i < 20; i++) begin
         d = $urandom;
         if (d == m_exp) d = ~d;
         beat(d);
         beat(m_exp);
      end

      cur_test = "clear_with_beat";
      cycle(1'b1, 2'd0, m_exp, 1'b1);
      run_seq(2'd0, 32'h3000, 6);

      cur_test = "mode_toggle";
      beat(32'h1234);
      cycle(1'b0, 2'd1, 32'h3006, 1'b1);
      idle(2'd1);

      cur_test = "async_reset";
      idle(2'd0);
      run_seq(2'd0, 32'h4000, 6);
      beat(32'hDEAD_BEEF);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_all_zero();
      model_reset();
      rstn = 1'b1;
      run_seq(2'd0, 32'h5000, 6);

      cur_test = "random";
      for (int i = 0; i < 400; i++) begin
         logic [1:0] md;
         md = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(0, 3)) : cur_mode;
         d  = ($urandom_range(0, 15) == 0) ? 32'($urandom) : m_exp;
         cycle($urandom_range(0, 99) == 0, md, d, $urandom_range(0, 3) != 0);
      end

      cur_test = "drain";
      @(posedge clk);
      #2;
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pattern_checker.md
# pattern_checker

Parametrised, multi-mode data-pattern checker for streams from the PCIe/DMA test path. It hunts for pattern lock, then counts mismatching beats with a saturating counter and captures the first error. On an error it resynchronises to the received data, and it drops lock after a run of consecutive errors. It sits at the sink end of a loopback or DMA read stream, and software reads its counters.

## Interface
- DATA_WIDTH, 32, width of checked data word (>= 2)
- CNT_WIDTH, 16, width of error counter
- LOCK_THRESH, 4, consecutive matching beats in HUNT needed to lock (>= 1)
- UNLOCK_THRESH, 8, consecutive mismatching beats in LOCKED that drop lock (>= 1)
- clk  input  1  sole clock, rising edge
- rstn  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of state, counters and capture
- mode  input  2  pattern: 0 increment, 1 decrement, 2 constant, 3 walking (rotate left by 1)
- data_in  input  DATA_WIDTH  received word
- data_valid  input  1  data_in qualifier
- locked  output  1  checker is in LOCKED
- err_count  output  CNT_WIDTH  mismatching beats while LOCKED, saturating
- err_sticky  output  1  at least one error since reset/clear
- first_exp  output  DATA_WIDTH  expected value at first error
- first_got  output  DATA_WIDTH  received value at first error

## Operation
- next(d): mode 0 d+1 mod 2^DATA_WIDTH; mode 1 d-1 mod 2^DATA_WIDTH; mode 2 d; mode 3 {d[W-2:0], d[W-1]}.
- Internal registers: expected (W), primed (1), run (counter wide enough for max(LOCK_THRESH, UNLOCK_THRESH)), mode_r (2), state {HUNT, LOCKED}.
- A beat is a cycle with data_valid=1. Nothing changes on non-beat cycles, except through clear or a mode change.
- HUNT, primed=0: the beat loads expected<=next(data_in), sets primed=1 and sets run=0.
- HUNT, primed=1:
  - match (data_in==expected): run+1 and expected<=next(data_in). When run+1==LOCK_THRESH, go to LOCKED and set run=0.
  - mismatch: run=0 and expected<=next(data_in). No error is counted in HUNT.
- LOCKED:
  - match: expected<=next(data_in) and run=0.
  - mismatch: resync with expected<=next(data_in), err_count+1 (held at all-ones when already all-ones), run+1.
  - When run+1==UNLOCK_THRESH, go to HUNT and set primed=1, run=0. The error on that beat is still counted.
- First error: on the first counted mismatch while err_sticky=0, capture first_exp<=expected and first_got<=data_in, and set err_sticky=1. Later errors do not change the capture.
- Mode change: mode_r samples mode every cycle. If mode!=mode_r, go to HUNT and set primed=0, run=0. A beat in that same cycle is ignored. Counters and capture are kept.
- clear=1: state HUNT, primed=0, run=0, err_count=0, err_sticky=0, first_exp=0, first_got=0. clear has priority over a concurrent beat, and that beat is dropped.
- Reset: all registers go to 0, state goes to HUNT, mode_r=0.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Reset values: locked=0, err_count=0, err_sticky=0, first_exp=0, first_got=0.
- A beat in cycle N is reflected in the outputs at cycle N+1 (1-cycle latency).
- locked rises in the cycle after the LOCK_THRESH-th consecutive matching primed beat, so at minimum LOCK_THRESH+1 beats from HUNT.
- Back-to-back beats are sustained at 1 per cycle with no stall; there is no backpressure output.
- Asserting rstn mid-stream clears everything immediately, asynchronously. The first beat after deassertion is a priming beat.
- Wrap-around: increment from all-ones to 0 and decrement from 0 to all-ones are matches, not errors.

## Test plan
- Lock: mode 0, W=32, LOCK_THRESH=4, beats 0x10..0x14 back-to-back -> locked=1 the cycle after beat 0x14, err_count=0, err_sticky=0.
- Single error and resync: after lock, beats 0x15, 0x99, 0x9A, 0x9B -> err_count=1, first_exp=0x16, first_got=0x99, locked stays 1, and no further errors.
- Wrap and modes:
  - mode 0 beats 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 count no errors.
  - mode 1 beats 2, 1, 0, 0xFFFFFFFF count no errors.
  - mode 3 beats 0x1, 0x2, …, 0x80000000, 0x1 count no errors.
- Unlock: locked, UNLOCK_THRESH=8, 8 random mismatching beats -> err_count=8, locked=0 in the cycle after the 8th beat. A further clean 4-beat run relocks with no extra count.
- Saturation: CNT_WIDTH=4, locked, feed >15 non-consecutive errors with a matching beat between each -> err_count holds at 0xF.
- Clear, mode change and reset:
  - clear pulsed together with a beat -> all outputs 0 next cycle and the beat is ignored.
  - mode toggled while locked -> locked=0 next cycle with counters retained.
  - rstn pulsed mid-stream -> all outputs 0 immediately.
